// File: rtl/tmboc_design_sel_ctrl_pkg.sv
// Shared definitions for the TMBoC design-select sequencer: state encodings,
// default parameter values and the delay-counter width helper.
package tmboc_design_sel_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_SWITCH = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } state_e;

    localparam int DEF_N_DESIGNS     = 8;
    localparam int DEF_SEL_W         = 3;
    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_DEFAULT_SEL   = 0;

    // Counter holds at most max(a,b)-1; keep at least one bit for the degenerate 1-cycle case.
    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tmboc_design_sel_ctrl_delay_ctr.sv
// Loadable down-counter with a zero flag; times the HOLD and SETTLE phases.
module tmboc_design_sel_ctrl_delay_ctr #(
    parameter int CNT_W   = 4,
    parameter int RST_VAL = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturates at zero; a fresh load on state entry is the only way back up.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= CNT_W'(RST_VAL);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tmboc_design_sel_ctrl.sv
// Design-select sequencer: every switch runs reset/gate -> select change -> settle -> release,
// so the pad select never moves while any user design is out of reset.
module tmboc_design_sel_ctrl
    import tmboc_design_sel_ctrl_pkg::*;
#(
    parameter int N_DESIGNS     = DEF_N_DESIGNS,
    parameter int SEL_W         = DEF_SEL_W,
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int DEFAULT_SEL   = DEF_DEFAULT_SEL
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [SEL_W-1:0]     sel_req_i,
    input  logic                 sel_valid_i,
    output logic                 sel_ack_o,
    output logic                 invalid_o,
    output logic                 busy_o,
    output logic [SEL_W-1:0]     active_sel_o,
    output logic [N_DESIGNS-1:0] design_rst_o,
    output logic                 io_gate_o,
    output logic [1:0]           dbg_state_o
);

    localparam int             CNT_W = cnt_width(RST_CYCLES, SETTLE_CYCLES);
    localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N_DESIGNS);

    // sel_valid_i is a single-cycle strobe with no ready: it is only honoured in RUN,
    // and every other strobe is answered with a one-cycle invalid_o pulse.
    state_e                 state_q, state_d;
    logic [SEL_W-1:0]       pending_q, pending_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [N_DESIGNS-1:0]   rst_q, rst_d;
    logic                   gate_q, gate_d;
    logic                   busy_q, busy_d;
    logic                   ack_q, ack_d;
    logic                   inv_q, inv_d;
    logic                   ctr_load;
    logic [CNT_W-1:0]       ctr_load_val;
    logic                   ctr_dec;
    logic                   ctr_zero;
    logic                   req_out_of_range;

    assign req_out_of_range = ({1'b0, sel_req_i} >= N_LIM);

    tmboc_design_sel_ctrl_delay_ctr #(
        .CNT_W   (CNT_W),
        .RST_VAL (RST_CYCLES - 1)
    ) u_delay_ctr (
        .clk_i      (wb_clk_i),
        .rst_i      (wb_rst_i),
        .load_i     (ctr_load),
        .load_val_i (ctr_load_val),
        .dec_i      (ctr_dec),
        .zero_o     (ctr_zero)
    );

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        sel_d        = sel_q;
        ctr_load     = 1'b0;
        ctr_load_val = '0;
        ctr_dec      = 1'b0;
        ack_d        = 1'b0;
        inv_d        = 1'b0;

        case (state_q)
            ST_HOLD: begin
                ctr_dec = 1'b1;
                if (ctr_zero) begin
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                sel_d        = pending_q;
                ctr_load     = 1'b1;
                ctr_load_val = CNT_W'(SETTLE_CYCLES - 1);
                state_d      = ST_SETTLE;
            end
            ST_SETTLE: begin
                ctr_dec = 1'b1;
                if (ctr_zero) begin
                    state_d = ST_RUN;
                    ack_d   = 1'b1;
                end
            end
            default: begin
                if (sel_valid_i) begin
                    if (req_out_of_range) begin
                        inv_d = 1'b1;
                    end else begin
                        // Re-selecting the active design is a deliberate full restart of it.
                        pending_d    = sel_req_i;
                        ctr_load     = 1'b1;
                        ctr_load_val = CNT_W'(RST_CYCLES - 1);
                        state_d      = ST_HOLD;
                    end
                end
            end
        endcase

        if (sel_valid_i && (state_q != ST_RUN)) begin
            inv_d = 1'b1;
        end

        gate_d = (state_d != ST_RUN);
        busy_d = (state_d != ST_RUN);
        for (int i = 0; i < N_DESIGNS; i++) begin
            rst_d[i] = !((state_d == ST_RUN) && (sel_d == SEL_W'(i)));
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_HOLD;
            pending_q <= SEL_W'(DEFAULT_SEL);
            sel_q     <= SEL_W'(DEFAULT_SEL);
            rst_q     <= '1;
            gate_q    <= 1'b1;
            busy_q    <= 1'b1;
            ack_q     <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            sel_q     <= sel_d;
            rst_q     <= rst_d;
            gate_q    <= gate_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            inv_q     <= inv_d;
        end
    end

    assign sel_ack_o    = ack_q;
    assign invalid_o    = inv_q;
    assign busy_o       = busy_q;
    assign active_sel_o = sel_q;
    assign design_rst_o = rst_q;
    assign io_gate_o    = gate_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_tmboc_design_sel_ctrl.sv
// Bench for tmboc_design_sel_ctrl with six designs, so index 5 is the last valid one
// and 6/7 are out of range. Ack/invalid pulses are checked against expected queues.
module tb_tmboc_design_sel_ctrl;

  localparam int N  = 6;
  localparam int SW = 3;
  localparam int W  = 27;

  logic          wb_clk = 1'b0;
  logic          wb_rst = 1'b1;
  logic [SW-1:0] sel_req = '0;
  logic          sel_valid = 1'b0;
  logic          sel_ack_o;
  logic          invalid_o;
  logic          busy_o;
  logic [SW-1:0] active_sel_o;
  logic [N-1:0]  design_rst_o;
  logic          io_gate_o;
  logic [1:0]    dbg_state_o;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] ack_exp_q[$];
  logic [W-1:0] inv_exp_q[$];

  tmboc_design_sel_ctrl #(
    .N_DESIGNS     (N),
    .SEL_W         (SW),
    .RST_CYCLES    (16),
    .SETTLE_CYCLES (4),
    .DEFAULT_SEL   (0)
  ) dut (
    .wb_clk_i     (wb_clk),
    .wb_rst_i     (wb_rst),
    .sel_req_i    (sel_req),
    .sel_valid_i  (sel_valid),
    .sel_ack_o    (sel_ack_o),
    .invalid_o    (invalid_o),
    .busy_o       (busy_o),
    .active_sel_o (active_sel_o),
    .design_rst_o (design_rst_o),
    .io_gate_o    (io_gate_o),
    .dbg_state_o  (dbg_state_o)
  );

  // clock / reset
  always #5 wb_clk = ~wb_clk;
  always @(posedge wb_clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] pack(input int c, input logic [SW-1:0] s,
                                        input logic [N-1:0] r, input logic g, input logic b);
    return {16'(c), s, r, g, b};
  endfunction

  function automatic logic [N-1:0] run_rst(input logic [SW-1:0] s);
    logic [N-1:0] one;
    one = 1;
    return ~(one << s);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge wb_clk) begin
    if (sel_ack_o === 1'b1) begin
      if (ack_exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
      end else begin
        check("ack_pulse", 32'(pack(cyc, active_sel_o, design_rst_o, io_gate_o, busy_o)),
              32'(ack_exp_q.pop_front()));
      end
    end
    if (invalid_o === 1'b1) begin
      if (inv_exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_invalid: got invalid at cycle %0d expected none", cyc);
      end else begin
        check("invalid_pulse", 32'(pack(cyc, active_sel_o, design_rst_o, io_gate_o, busy_o)),
              32'(inv_exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge wb_clk);
      #1;
    end
  endtask

  task automatic check_outs(input string name, input logic [SW-1:0] s, input logic [N-1:0] r,
                            input logic g, input logic b);
    check(name, 32'({active_sel_o, design_rst_o, io_gate_o, busy_o}), 32'({s, r, g, b}));
  endtask

  task automatic strobe(input logic [SW-1:0] s, output int cs);
    sel_valid = 1'b1;
    sel_req   = s;
    step(1);
    sel_valid = 1'b0;
    cs        = cyc;
  endtask

  task automatic apply_reset(output int c0);
    wb_rst = 1'b1;
    step(1);
    wb_rst = 1'b0;
    c0     = cyc;
    check_outs("reset_outputs", 3'd0, 6'h3F, 1'b1, 1'b1);
    check("reset_pulses", 32'({sel_ack_o, invalid_o, dbg_state_o}), 32'({1'b0, 1'b0, 2'd0}));
    ack_exp_q.push_back(pack(c0 + 21, 3'd0, run_rst(3'd0), 1'b0, 1'b0));
  endtask

  task automatic wait_run();
    int k;
    k = 0;
    while (busy_o !== 1'b0 && k < 60) begin
      step(1);
      k++;
    end
    check("run_reached", 32'(busy_o), 32'(0));
  endtask

  // directed sequence
  initial begin
    int c0;
    int cs;
    int cs2;

    step(1);
    // 1: post-reset sequence to default design 0
    apply_reset(c0);
    step(20);
    check("busy_cycle21", 32'(busy_o), 32'(1));
    step(1);
    check_outs("run_after_reset", 3'd0, 6'h3E, 1'b0, 1'b0);
    check("state_run", 32'(dbg_state_o), 32'(3));

    // 2: switch 0 -> 5
    strobe(3'd5, cs);
    ack_exp_q.push_back(pack(cs + 21, 3'd5, run_rst(3'd5), 1'b0, 1'b0));
    check_outs("switch5_hold", 3'd0, 6'h3F, 1'b1, 1'b1);
    step(16);
    check("sel_before_switch", 32'(active_sel_o), 32'(0));
    step(1);
    check("sel_after_switch", 32'(active_sel_o), 32'(5));
    check("settle_rst", 32'(design_rst_o), 32'(6'h3F));
    step(3);
    check("busy_settle_end", 32'(busy_o), 32'(1));
    step(1);
    check_outs("run_on5", 3'd5, 6'h1F, 1'b0, 1'b0);

    // 3: restart of the same design
    strobe(3'd5, cs);
    ack_exp_q.push_back(pack(cs + 21, 3'd5, run_rst(3'd5), 1'b0, 1'b0));
    check_outs("restart5_hold", 3'd5, 6'h3F, 1'b1, 1'b1);
    step(17);
    check("restart_sel", 32'(active_sel_o), 32'(5));
    wait_run();
    check_outs("restart5_run", 3'd5, 6'h1F, 1'b0, 1'b0);

    // 4: out-of-range indices
    strobe(3'd7, cs);
    inv_exp_q.push_back(pack(cs, 3'd5, 6'h1F, 1'b0, 1'b0));
    strobe(3'd6, cs);
    inv_exp_q.push_back(pack(cs, 3'd5, 6'h1F, 1'b0, 1'b0));
    step(1);
    check_outs("after_invalid", 3'd5, 6'h1F, 1'b0, 1'b0);
    check("state_after_invalid", 32'(dbg_state_o), 32'(3));

    // 5: strobe during HOLD is dropped
    strobe(3'd1, cs);
    ack_exp_q.push_back(pack(cs + 21, 3'd1, run_rst(3'd1), 1'b0, 1'b0));
    step(2);
    strobe(3'd2, cs2);
    inv_exp_q.push_back(pack(cs + 3, 3'd5, 6'h3F, 1'b1, 1'b1));
    check("hold_strobe_cycle", 32'(cs2), 32'(cs + 3));
    wait_run();
    check_outs("run_on1", 3'd1, 6'h3D, 1'b0, 1'b0);

    // 6: reset in SETTLE drops the request toward 3
    strobe(3'd3, cs);
    ack_exp_q.push_back(pack(cs + 21, 3'd3, run_rst(3'd3), 1'b0, 1'b0));
    step(17);
    check("settle_sel3", 32'(active_sel_o), 32'(3));
    step(1);
    ack_exp_q.delete();
    apply_reset(c0);
    wait_run();
    check("rerun_cycle", 32'(cyc), 32'(c0 + 21));
    check_outs("run_default", 3'd0, 6'h3E, 1'b0, 1'b0);
    step(25);
    check_outs("still_default", 3'd0, 6'h3E, 1'b0, 1'b0);

    check("ack_q_drained", 32'(ack_exp_q.size()), 32'(0));
    check("inv_q_drained", 32'(inv_exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
